// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Constants and types shared by the MIPS instruction-fetch front end.
//   No ports. Provides address/instruction widths, the reset fetch address,
//   the packed queue entry layout and a word-address increment helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int ADDR_W = 30;  // word address, byte address bits [31:2]
    localparam int INST_W = 32;
    localparam int FIFO_W = ADDR_W + INST_W;

    localparam logic [ADDR_W-1:0] RESET_PC_WORD = 30'h100000;  // byte 0x00400000
    localparam logic [INST_W-1:0] NOP_INST      = 32'h0;

    // One prefetch queue slot: return address of the instruction plus the
    // instruction itself. pc_plus4 occupies the upper bits of the flat vector.
    typedef struct packed {
        logic [ADDR_W-1:0] pc_plus4;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Next sequential word address; wraps 30'h3FFFFFFF -> 30'h0 silently.
    function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] addr);
        return addr + 30'd1;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
//   Circular buffer of DEPTH entries, WIDTH bits each, with no bypass: a
//   pushed entry is visible at rd_data at the earliest on the next cycle.
//   Ports:
//     clk      in   clock, all updates on the rising edge
//     rst_n    in   synchronous active-low reset; clears pointers, count, storage
//     flush    in   empty the buffer (pointers/count to 0); wins over push/pop
//     push     in   write wr_data at the tail (caller guarantees space or pop)
//     pop      in   advance the head (caller guarantees count != 0)
//     wr_data  in   entry to write
//     rd_data  out  entry at the head slot (stale when count == 0)
//     count    out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module prefetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FIFO_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // Storage is left untouched; only the bookkeeping is cleared.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wr_data;
                tail_d        = tail_q + 1'b1;  // DEPTH is a power of two: wraps for free
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rd_data = mem_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// -----------------------------------------------------------------------------
// fetch_queue_unit
//   Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the fetch
//   PC, drives the combinational instruction memory and buffers fetched
//   {PC+4, instruction} pairs in a prefetch queue feeding decode.
//   Ports:
//     clk              in   clock
//     reset            in   synchronous active-low reset; beats redirect/push/pop
//     imem_addr        out  word address to instruction memory (= fetch PC)
//     imem_data        in   instruction read combinationally at imem_addr
//     out_valid        out  queue head holds a live instruction for decode
//     out_ready        in   decode takes the head this cycle (~stall)
//     out_inst         out  instruction at the queue head
//     out_pc_plus4     out  word address of the head instruction plus 1
//     redirect         in   taken branch resolved this cycle
//     redirect_target  in   word address to restart fetch from
//     count            out  queue occupancy, 0..DEPTH
//
//   Decode handshake: the head transfers on a cycle where out_valid and
//   out_ready are both high. out_valid never depends on out_ready; out_ready
//   may be driven from anything. While redirect is high out_valid is held low,
//   so a squashed instruction can never transfer.
// -----------------------------------------------------------------------------
module fetch_queue_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_WORD,
    localparam int               CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc_plus4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push;
    logic              pop;
    logic              valid;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head_entry;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        valid = (fifo_count != '0) & ~redirect;
        pop   = valid & out_ready;
        // A full queue can still accept a fetch when the head leaves in the
        // same cycle, so sustained throughput stays at one per cycle.
        push  = ~redirect & ((fifo_count < DEPTH_C) | pop);

        wr_entry.pc_plus4 = next_word_addr(pc_q);
        wr_entry.inst     = imem_data;

        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = next_word_addr(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_prefetch_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush   (redirect),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .count   (fifo_count)
    );

    assign imem_addr    = pc_q;
    assign out_valid    = valid;
    assign out_inst     = head_entry.inst;
    assign out_pc_plus4 = head_entry.pc_plus4;
    assign count        = fifo_count;

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Owns the fetch PC and drives the combinational instruction memory.
- Buffers fetched {PC+4, instruction} pairs in a small circular prefetch queue feeding the decode stage.
- Decode back-pressure (load-use stall) is absorbed by the queue. A taken-branch redirect from execute flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 30'h100000, word address loaded into the fetch PC on reset (byte address 0x00400000).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous and active-low; one clock.
- imem_addr  output  30  word address [31:2] to instruction memory; equals the fetch PC.
- imem_data  input  32  instruction read combinationally at imem_addr.
- out_valid  output  1  queue head holds a valid instruction for decode.
- out_ready  input  1  decode accepts the head this cycle (driven as ~stall).
- out_inst  output  32  instruction at the queue head.
- out_pc_plus4  output  30  word address of the head instruction plus 1.
- redirect  input  1  taken branch resolved this cycle.
- redirect_target  input  30  word address to restart fetch from.
- count  output  3  current queue occupancy, 0..DEPTH.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch PC <= RESET_PC; head, tail and count <= 0; all storage <= 0.
  - After reset: out_valid=0, out_inst=0, out_pc_plus4=0.
  - Reset has priority over redirect, push and pop, and takes effect mid-operation regardless of queue contents.
- Combinational signals:
  - out_valid = (count != 0) & ~redirect.
  - pop = out_valid & out_ready.
  - push = ~redirect & ((count < DEPTH) | pop).
- Normal cycle (no reset, no redirect):
  - If push: store {imem_addr+1, imem_data} at tail; tail <= tail+1 mod DEPTH; fetch PC <= fetch PC + 1.
  - If pop: head <= head+1 mod DEPTH.
  - count <= count + push - pop.
- Simultaneous push and pop when full: both occur; count stays DEPTH.
- Simultaneous push and pop when count==1: the new entry becomes the head next cycle; no bubble.
- Empty with out_ready=1: no pop; count stays 0.
- Latency: an instruction fetched in cycle N is visible at the outputs in cycle N+1. There is no bypass from imem_data to out_inst.
- Redirect (priority over push and pop):
  - Next edge: count, head, tail <= 0; fetch PC <= redirect_target; no push.
  - During the redirect cycle out_valid is forced to 0, so decode never latches a squashed instruction.
  - The target instruction appears at out_valid two cycles after redirect asserts (2-cycle branch penalty).
- Wrap-around:
  - Queue pointers wrap modulo DEPTH.
  - Fetch PC and out_pc_plus4 wrap 30'h3FFFFFFF -> 30'h0 with no error.
- Stored entries are never modified except by push. out_inst and out_pc_plus4 reflect the head slot even when out_valid=0; their value then is a don't-care.

Decomposition:
- Shared package (mips_pkg): RESET_PC_WORD = 30'h100000, NOP_INST = 32'h0, ADDR_W = 30, INST_W = 32.
- One natural sub-module, prefetch_fifo: a parameterised circular buffer of width ADDR_W+INST_W with push, pop, flush, count, head data and synchronous active-low reset.
- The top level holds the fetch PC, the push/pop/redirect logic and the imem connection.

Test Plan:
- Reset then free-run: reset low 1 cycle, out_ready=1, imem returns word addr -> imem_addr 30'h100000, 30'h100001, ...; first out_valid on cycle 2 with out_pc_plus4 = 30'h100001, then one instruction per cycle, count steady at 1.
- Fill under stall: out_ready=0 for 8 cycles -> count reaches 4 after 4 edges; imem_addr holds 30'h100004; release stall -> heads 0x100001..0x100004 pop in order, no loss or duplication.
- Full with simultaneous pop: count=4, out_ready=1 -> push and pop each cycle; count stays 4; imem_addr advances by 1 per cycle.
- Redirect: count=3, redirect=1 with target 30'h100040 -> out_valid=0 that cycle; next cycle count=0, imem_addr=30'h100040; following cycle out_valid=1, out_pc_plus4=30'h100041.
- Redirect with reset in the same cycle: both asserted, target 30'h200 -> fetch PC = 30'h100000 and count=0 (reset wins).
- Pointer and PC wrap: start at 30'h3FFFFFFE and run 10 cycles with random out_ready -> out_pc_plus4 sequence 3FFFFFFF, 0, 1...; data order preserved across head/tail wrap.
